// File: rtl/mem_xfer_sequencer.sv
// Command-driven write/read sequencer for a 4x4 bit-cell memory with a 4-phase req_a/ack_a transfer handshake.
// Optional ack timeout with sticky err flag: define MEM_XFER_TIMEOUT_EN.
module mem_xfer_sequencer #(
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 1,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 8
) (
    input  logic             clkA,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic [1:0]       cmd_ad,
    input  logic [3:0]       cmd_data,
    output logic             en,
    output logic [1:0]       ad,
    output logic             op,
    output logic [3:0]       din,
    output logic             req_a,
    input  logic             ack_a,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             busy,
    output logic             err,
    input  logic             err_clr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_REQ   = 3'd3;
    localparam logic [2:0] S_REL   = 3'd4;

    localparam int PH_MAX = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    logic [2:0]      state;
    logic [PH_W-1:0] phase;
    logic            ack_m;
    logic            ack_s;
    logic            seen_low;
    logic            req_done;
    logic            timeout;

    assign cmd_ready = (state == S_IDLE) && rst_n;
    // A stale ack that is already high when REQ is entered must first be seen low.
    assign req_done  = ack_s && seen_low;

    // NOTE: every flop uses <= so all blocks sample the same pre-edge values.
    always_ff @(posedge clkA) begin
        if (!rst_n) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= ack_a;
            ack_s <= ack_m;
        end
    end

`ifdef MEM_XFER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] tcnt;
    logic            to_hit;

    assign to_hit  = (tcnt == TO_W'(TIMEOUT - 1));
    assign timeout = to_hit && (((state == S_REQ) && !req_done) || ((state == S_REL) && ack_s));

    // Cleared outside REQ/RELEASE and on the REQ->RELEASE step, so each wait starts from zero.
    always_ff @(posedge clkA) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (((state != S_REQ) && (state != S_REL)) || ((state == S_REQ) && req_done)) begin
            tcnt <= '0;
        end else if (!to_hit) begin
            tcnt <= tcnt + TO_W'(1);
        end
    end

    always_ff @(posedge clkA) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign err        = 1'b0;
    assign unused_cfg = err_clr | (TIMEOUT == 0);
`endif

    // NOTE: no memory arrays here, so every register is cleared by the synchronous reset.
    always_ff @(posedge clkA) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            phase    <= '0;
            seen_low <= 1'b0;
            en       <= 1'b0;
            ad       <= 2'd0;
            op       <= 1'b0;
            din      <= 4'd0;
            req_a    <= 1'b0;
            busy     <= 1'b0;
            wr_cnt   <= '0;
            xfer_cnt <= '0;
        end else if (timeout) begin
            state <= S_IDLE;
            en    <= 1'b0;
            req_a <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state <= cmd_wr ? S_WRITE : S_READ;
                        phase <= '0;
                        en    <= 1'b1;
                        ad    <= cmd_ad;
                        op    <= !cmd_wr;
                        din   <= cmd_wr ? cmd_data : din;
                        busy  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (phase == PH_W'(WR_CYCLES - 1)) begin
                        state  <= S_IDLE;
                        en     <= 1'b0;
                        busy   <= 1'b0;
                        wr_cnt <= wr_cnt + CNT_W'(1);
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                S_READ: begin
                    if (phase == PH_W'(RD_CYCLES - 1)) begin
                        state    <= S_REQ;
                        req_a    <= 1'b1;
                        seen_low <= 1'b0;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                S_REQ: begin
                    if (req_done) begin
                        state <= S_REL;
                        req_a <= 1'b0;
                        en    <= 1'b0;
                    end else if (!ack_s) begin
                        seen_low <= 1'b1;
                    end
                end
                S_REL: begin
                    if (!ack_s) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        xfer_cnt <= xfer_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    en    <= 1'b0;
                    req_a <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_xfer_sequencer.sv
// Self-checking bench for mem_xfer_sequencer: directed scenarios plus random traffic
// compared every cycle against a transaction-timeline model of the sequencer.
module tb_mem_xfer_sequencer;

    localparam int WR_CYCLES = 2;
    localparam int RD_CYCLES = 1;
    localparam int TIMEOUT   = 8;
    localparam int CNT_W     = 4;
    localparam int CNT_MOD   = 1 << CNT_W;
`ifdef MEM_XFER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clkA = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_wr = 1'b0;
    logic [1:0]       cmd_ad = 2'd0;
    logic [3:0]       cmd_data = 4'd0;
    logic             en;
    logic [1:0]       ad;
    logic             op;
    logic [3:0]       din;
    logic             req_a;
    logic             ack_a = 1'b0;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] xfer_cnt;
    logic             busy;
    logic             err;
    logic             err_clr = 1'b0;

    mem_xfer_sequencer #(
        .WR_CYCLES(WR_CYCLES),
        .RD_CYCLES(RD_CYCLES),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W)
    ) dut (
        .clkA     (clkA),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr   (cmd_wr),
        .cmd_ad   (cmd_ad),
        .cmd_data (cmd_data),
        .en       (en),
        .ad       (ad),
        .op       (op),
        .din      (din),
        .req_a    (req_a),
        .ack_a    (ack_a),
        .wr_cnt   (wr_cnt),
        .xfer_cnt (xfer_cnt),
        .busy     (busy),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 clkA = ~clkA;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    // ---------------- ack responder (single driver of ack_a) ----------------
    bit auto_ack = 1'b0;
    bit man_ack  = 1'b0;
    int resp_wait = 0;

    always @(posedge clkA) begin
        #2;
        if (!auto_ack) begin
            ack_a = man_ack;
        end else if (req_a != ack_a) begin
            if (resp_wait == 0) begin
                ack_a     = req_a;
                resp_wait = $urandom_range(0, 2);
            end else begin
                resp_wait = resp_wait - 1;
            end
        end
    end

    // ---------------- reference model: a timeline of each command ----------------
    bit       m_en = 0, m_op = 0, m_req = 0, m_busy = 0, m_err = 0;
    bit [1:0] m_ad = 0;
    bit [3:0] m_din = 0;
    int       m_wr = 0, m_xfer = 0;
    bit       m_a1 = 0, m_as = 0;
    bit       s_valid, s_wr;
    bit [1:0] s_ad;
    bit [3:0] s_data;

    // Advance one clock edge; report reset and the synchronised ack the design acts on there.
    task automatic edge_step(output bit rst_hit, output bit ack_seen);
        @(posedge clkA);
        ack_seen = m_as;
        s_valid  = cmd_valid;
        s_wr     = cmd_wr;
        s_ad     = cmd_ad;
        s_data   = cmd_data;
        rst_hit  = !rst_n;
        if (rst_hit) begin
            m_en = 0; m_op = 0; m_req = 0; m_busy = 0; m_err = 0;
            m_ad = 0; m_din = 0; m_wr = 0; m_xfer = 0; m_a1 = 0; m_as = 0;
        end else begin
            m_as = m_a1;
            m_a1 = ack_a;
            if (err_clr) m_err = 0;
        end
    endtask

    task automatic model_txn();
        bit r, a, wr, seen_low;
        int t;
        wr     = s_wr;
        m_en   = 1;
        m_op   = !wr;
        m_ad   = s_ad;
        m_busy = 1;
        if (wr) m_din = s_data;
        if (wr) begin
            for (int i = 0; i < WR_CYCLES; i++) begin
                edge_step(r, a);
                if (r) return;
            end
            m_en = 0; m_busy = 0;
            m_wr = (m_wr + 1) % CNT_MOD;
            return;
        end
        for (int i = 0; i < RD_CYCLES; i++) begin
            edge_step(r, a);
            if (r) return;
        end
        m_req    = 1;
        seen_low = 0;
        t        = 0;
        forever begin
            edge_step(r, a);
            if (r) return;
            t++;
            if (a && seen_low) begin
                m_req = 0; m_en = 0;
                break;
            end
            if (!a) seen_low = 1;
            if (TO_EN && t == TIMEOUT) begin
                m_req = 0; m_en = 0; m_busy = 0; m_err = 1;
                return;
            end
        end
        t = 0;
        forever begin
            edge_step(r, a);
            if (r) return;
            t++;
            if (!a) begin
                m_busy = 0;
                m_xfer = (m_xfer + 1) % CNT_MOD;
                return;
            end
            if (TO_EN && t == TIMEOUT) begin
                m_busy = 0; m_err = 1;
                return;
            end
        end
    endtask

    initial begin : model
        bit r, a;
        forever begin
            edge_step(r, a);
            if (!r && s_valid) model_txn();
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_on = 1'b0;

    always @(negedge clkA) begin
        if (cmp_on) begin
            check("cmd_ready", 32'(cmd_ready), 32'(rst_n && !m_busy));
            check("en", 32'(en), 32'(m_en));
            check("req_a", 32'(req_a), 32'(m_req));
            check("busy", 32'(busy), 32'(m_busy));
            check("err", 32'(err), 32'(m_err));
            check("wr_cnt", 32'(wr_cnt), 32'(m_wr));
            check("xfer_cnt", 32'(xfer_cnt), 32'(m_xfer));
            if (m_en) begin
                check("ad", 32'(ad), 32'(m_ad));
                check("op", 32'(op), 32'(m_op));
                if (!m_op) check("din", 32'(din), 32'(m_din));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_cmd(input bit wr, input bit [1:0] a, input bit [3:0] d);
        bit ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_ad    = a;
        cmd_data  = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge clkA);
            if (cmd_ready) begin
                @(posedge clkA);
                #1;
                ok = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        check("cmd_accept", 32'(ok), 32'd1);
    endtask

    // which: 0 = req_a, 1 = busy. Returns at the negedge where the level is seen.
    task automatic wait_for(input int which, input bit lvl, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clkA);
            if (((which == 0) ? req_a : busy) == lvl) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic resync(input int n);
        repeat (n) @(posedge clkA);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int n;

        // T1: reset held with a command pending
        cmd_valid = 1'b1;
        @(posedge clkA);
        #1;
        cmp_on = 1'b1;
        resync(2);
        check("t1_ready_in_reset", 32'(cmd_ready), 32'd0);
        check("t1_en", 32'(en), 32'd0);
        check("t1_req", 32'(req_a), 32'd0);
        check("t1_wr_cnt", 32'(wr_cnt), 32'd0);
        check("t1_xfer_cnt", 32'(xfer_cnt), 32'd0);
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clkA);
        check("t1_ready_after", 32'(cmd_ready), 32'd1);
        resync(1);

        // T2: write A to word 2, en held exactly WR_CYCLES cycles
        send_cmd(1'b1, 2'd2, 4'hA);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clkA);
            if (en) begin
                n++;
                check("t2_ad", 32'(ad), 32'd2);
                check("t2_din", 32'(din), 32'hA);
                check("t2_op", 32'(op), 32'd0);
            end
        end
        check("t2_en_cycles", 32'(n), 32'd2);
        check("t2_wr_cnt", 32'(wr_cnt), 32'd1);
        resync(1);

        // T3: transfer; req_a drops two edges after the first edge that samples ack_a high
        send_cmd(1'b0, 2'd2, 4'h0);
        wait_for(0, 1'b1, "t3_req_rise");
        resync(3);
        man_ack = 1'b1;
        @(posedge clkA);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clkA);
            if (!req_a) break;
            n++;
        end
        check("t3_req_hold", 32'(n), 32'd2);
        check("t3_en_release", 32'(en), 32'd0);
        resync(2);
        man_ack = 1'b0;
        wait_for(1, 1'b0, "t3_done");
        check("t3_xfer_cnt", 32'(xfer_cnt), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        resync(1);

        // T4: ack already high before the transfer is requested
        man_ack = 1'b1;
        resync(4);
        send_cmd(1'b0, 2'd1, 4'h0);
        wait_for(0, 1'b1, "t4_req_rise");
        resync(5);
        check("t4_req_stale", 32'(req_a), 32'd1);
        man_ack = 1'b0;
        resync(4);
        check("t4_req_low_ack", 32'(req_a), 32'd1);
        man_ack = 1'b1;
        wait_for(0, 1'b0, "t4_req_fall");
        resync(1);
        man_ack = 1'b0;
        wait_for(1, 1'b0, "t4_done");
        check("t4_xfer_cnt", 32'(xfer_cnt), 32'd2);
        resync(1);

        // T6: reset while req_a is high
        send_cmd(1'b0, 2'd3, 4'h0);
        wait_for(0, 1'b1, "t6_req_rise");
        #1;
        rst_n = 1'b0;
        resync(1);
        check("t6_req", 32'(req_a), 32'd0);
        check("t6_en", 32'(en), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_wr_cnt", 32'(wr_cnt), 32'd0);
        check("t6_xfer_cnt", 32'(xfer_cnt), 32'd0);
        rst_n = 1'b1;
        resync(1);

`ifdef MEM_XFER_TIMEOUT_EN
        // T5: ack never arrives; REQ times out after TIMEOUT cycles
        send_cmd(1'b0, 2'd0, 4'h0);
        wait_for(0, 1'b1, "t5_req_rise");
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clkA);
            if (!req_a) break;
            n++;
        end
        check("t5_req_cycles", 32'(n), 32'd8);
        check("t5_err", 32'(err), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_xfer_cnt", 32'(xfer_cnt), 32'd0);
        resync(1);
        err_clr = 1'b1;
        resync(1);
        err_clr = 1'b0;
        @(negedge clkA);
        check("t5_err_clr", 32'(err), 32'd0);
        resync(1);
`endif

        // Random traffic with an automatic ack responder; counters wrap at 2**CNT_W
        auto_ack = 1'b1;
        for (int k = 0; k < 250; k++) begin
            resync($urandom_range(0, 2));
            err_clr = ($urandom_range(0, 7) == 0);
            send_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end
        wait_for(1, 1'b0, "final_idle");
        resync(2);
        cmp_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
